// File: rtl/sb_io_counter_out.sv
// sb_io_counter_out
//   Parametrised up/down counter with wrap limit, step, load, enable and
//   one-shot halt. Drives a compare (PWM-style) pad signal plus count status.
//
//   Build option: define PIPLIN_SB_IO_EN to drive pad_out through an iCE40
//   SB_IO primitive. Without it, pad_out is driven directly from the
//   internal register. Cycle behaviour is the same either way.
//
//   Parameters
//     WIDTH  counter width in bits
//     LIMIT  highest count value (range 0..LIMIT), 1..2**WIDTH-1
//     STEP   increment/decrement per enabled cycle, 1..LIMIT
//   Ports
//     clock       sole clock, rising edge
//     reset_n     asynchronous active-low reset
//     enable      advance the count this cycle
//     load        load load_value (clamped to LIMIT) and restart in RUN
//     load_value  value to load
//     down        0 = count up, 1 = count down
//     one_shot    1 = halt at the boundary instead of wrapping
//     compare     pad threshold
//     count       current count
//     wrap        one-cycle pulse after a wrap or boundary hit
//     done        high while halted in one-shot mode
//     pad_out     registered (count < compare)
module sb_io_counter_out #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 2**WIDTH - 1,
  parameter int unsigned STEP  = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             down,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] compare,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             done,
  output logic             pad_out
);

  // All arithmetic is carried one bit wider than the count so that
  // count+STEP and count+LIMIT+1 never overflow when LIMIT = 2**WIDTH-1.
  localparam logic [WIDTH:0] LIM_X  = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MOD_X  = LIM_X + (WIDTH+1)'(1);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;
  logic             done_next;
  logic             pad_reg;
  logic             pad_valid;
  logic             pad_drive;

  logic [WIDTH:0]   count_x;
  logic [WIDTH:0]   load_x;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   up_wrapped;
  logic [WIDTH:0]   dn_diff;
  logic [WIDTH:0]   dn_wrapped;

  assign count_x    = {1'b0, count};
  assign load_x     = {1'b0, load_value};
  assign up_sum     = count_x + STEP_X;
  assign up_wrapped = up_sum - MOD_X;
  assign dn_diff    = count_x - STEP_X;
  assign dn_wrapped = count_x + MOD_X - STEP_X;

  always_comb begin
    count_next = count;
    state_next = state;
    wrap_next  = 1'b0;
    done_next  = done;
    if (load) begin
      count_next = (load_x > LIM_X) ? LIM_X[WIDTH-1:0] : load_value;
      state_next = RUN;
      done_next  = 1'b0;
    end else if (state == RUN && enable) begin
      if (!down) begin
        if (up_sum <= LIM_X) begin
          count_next = up_sum[WIDTH-1:0];
        end else begin
          wrap_next = 1'b1;
          if (one_shot) begin
            count_next = LIM_X[WIDTH-1:0];
            state_next = HALTED;
            done_next  = 1'b1;
          end else begin
            count_next = up_wrapped[WIDTH-1:0];
          end
        end
      end else begin
        if (count_x >= STEP_X) begin
          count_next = dn_diff[WIDTH-1:0];
        end else begin
          wrap_next = 1'b1;
          if (one_shot) begin
            count_next = '0;
            state_next = HALTED;
            done_next  = 1'b1;
          end else begin
            count_next = dn_wrapped[WIDTH-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      count     <= '0;
      wrap      <= 1'b0;
      done      <= 1'b0;
      pad_reg   <= 1'b0;
      pad_valid <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      wrap      <= wrap_next;
      done      <= done_next;
      pad_reg   <= (count_next < compare);
      pad_valid <= 1'b1;
    end
  end

  // The pad register cannot reset to a compare-dependent value, so until the
  // first edge after reset the pad shows (0 < compare) directly; count is 0
  // throughout that window, so this matches the registered value thereafter.
  assign pad_drive = pad_valid ? pad_reg : (compare != '0);

`ifdef PIPLIN_SB_IO_EN
  SB_IO #(
    .PIN_TYPE    (6'b011000),
    .PULLUP      (1'b0),
    .IO_STANDARD ("SB_LVCMOS")
  ) pad_io (
    .PACKAGE_PIN   (pad_out),
    .OUTPUT_ENABLE (1'b1),
    .D_OUT_0       (pad_drive)
  );
`else
  assign pad_out = pad_drive;
`endif

endmodule

// File: tb/tb_sb_io_counter_out.sv
module tb_sb_io_counter_out;

  typedef struct {
    int unsigned cnt;
    bit          halted;
    bit          wrap;
    bit          done;
    bit          pad;
  } mstate_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  // DUT a: defaults (WIDTH=8, LIMIT=255, STEP=1)
  logic       en_a = 0, ld_a = 0, dn_a = 0, os_a = 0;
  logic [7:0] lv_a = '0, cmp_a = '0;
  logic [7:0] count_a;
  logic       wrap_a, done_a, pad_a;

  // DUT b: WIDTH=4, LIMIT=9, STEP=3
  logic       en_b = 0, ld_b = 0, dn_b = 0, os_b = 0;
  logic [3:0] lv_b = '0, cmp_b = '0;
  logic [3:0] count_b;
  logic       wrap_b, done_b, pad_b;

  int unsigned checks = 0;
  int unsigned errors = 0;
  mstate_t     ma, mb;

  always #5 clock = ~clock;

  sb_io_counter_out dut_a (
    .clock(clock), .reset_n(reset_n), .enable(en_a), .load(ld_a),
    .load_value(lv_a), .down(dn_a), .one_shot(os_a), .compare(cmp_a),
    .count(count_a), .wrap(wrap_a), .done(done_a), .pad_out(pad_a)
  );

  sb_io_counter_out #(.WIDTH(4), .LIMIT(9), .STEP(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(en_b), .load(ld_b),
    .load_value(lv_b), .down(dn_b), .one_shot(os_b), .compare(cmp_b),
    .count(count_b), .wrap(wrap_b), .done(done_b), .pad_out(pad_b)
  );

  // Reference: counting modulo LIMIT+1, wrap when the step crosses a boundary.
  function automatic mstate_t model_step(mstate_t m, int unsigned lim, int unsigned stp,
                                         bit ld, int unsigned lv, bit en, bit dn, bit os,
                                         int unsigned cmp);
    mstate_t r = m;
    r.wrap = 0;
    if (ld) begin
      r.cnt = (lv > lim) ? lim : lv;
      r.halted = 0;
      r.done = 0;
    end else if (!m.halted && en) begin
      if (!dn) begin
        if (m.cnt + stp > lim) begin
          r.wrap = 1;
          if (os) begin r.cnt = lim; r.halted = 1; r.done = 1; end
          else r.cnt = (m.cnt + stp) % (lim + 1);
        end else r.cnt = m.cnt + stp;
      end else begin
        if (m.cnt < stp) begin
          r.wrap = 1;
          if (os) begin r.cnt = 0; r.halted = 1; r.done = 1; end
          else r.cnt = (m.cnt + lim + 1 - stp) % (lim + 1);
        end else r.cnt = m.cnt - stp;
      end
    end
    r.pad = (r.cnt < cmp);
    return r;
  endfunction

  function automatic mstate_t model_reset(int unsigned cmp);
    mstate_t r;
    r.cnt = 0; r.halted = 0; r.wrap = 0; r.done = 0; r.pad = (cmp != 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_models(input string tag);
    chk({tag, " a.count"}, 32'(count_a), ma.cnt);
    chk({tag, " a.wrap"},  32'(wrap_a),  32'(ma.wrap));
    chk({tag, " a.done"},  32'(done_a),  32'(ma.done));
    chk({tag, " a.pad"},   32'(pad_a),   32'(ma.pad));
    chk({tag, " b.count"}, 32'(count_b), mb.cnt);
    chk({tag, " b.wrap"},  32'(wrap_b),  32'(mb.wrap));
    chk({tag, " b.done"},  32'(done_b),  32'(mb.done));
    chk({tag, " b.pad"},   32'(pad_b),   32'(mb.pad));
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    ma = model_step(ma, 255, 1, ld_a, lv_a, en_a, dn_a, os_a, cmp_a);
    mb = model_step(mb, 9, 3, ld_b, lv_b, en_b, dn_b, os_b, cmp_b);
    #1;
    check_models(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    ma = model_reset(cmp_a);
    mb = model_reset(cmp_b);
    check_models("reset");
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int unsigned pad_hi;
    int unsigned pad_lo;
    int unsigned exp_b [8];
    exp_b = '{3, 6, 9, 2, 5, 8, 1, 4};

    // Free run at defaults with compare=64; DUT b free-runs with step 3.
    cmp_a = 8'd64;
    cmp_b = 4'd5;
    #2;
    do_reset();
    en_a = 1; en_b = 1;
    pad_hi = 0;
    for (int k = 1; k <= 257; k++) begin
      tick("freerun");
      chk("freerun count", 32'(count_a), k % 256);
      chk("freerun wrap", 32'(wrap_a), (k == 256) ? 1 : 0);
      if (k <= 256 && pad_a) pad_hi++;
      if (k <= 8) begin
        chk("step3 count", 32'(count_b), exp_b[k-1]);
        chk("step3 wrap", 32'(wrap_b), (k == 4 || k == 7) ? 1 : 0);
      end
    end
    chk("pwm64 high cycles", pad_hi, 64);

    // compare=0: constant low; compare=255: low only at count=255.
    cmp_a = 8'd0;
    for (int k = 0; k < 20; k++) tick("cmp0");
    cmp_a = 8'd255;
    pad_lo = 0;
    for (int k = 0; k < 256; k++) begin
      tick("cmp255");
      if (!pad_a) begin
        pad_lo++;
        chk("cmp255 low at", 32'(count_a), 255);
      end
    end
    chk("cmp255 low cycles", pad_lo, 1);

    // Down one-shot from 3.
    en_a = 0; ld_a = 1; lv_a = 8'd3;
    tick("load3");
    chk("load3 count", 32'(count_a), 3);
    ld_a = 0; dn_a = 1; os_a = 1; en_a = 1;
    for (int k = 0; k < 3; k++) tick("down");
    chk("down reach0", 32'(count_a), 0);
    chk("down reach0 done", 32'(done_a), 0);
    tick("boundary");
    chk("boundary count", 32'(count_a), 0);
    chk("boundary wrap", 32'(wrap_a), 1);
    chk("boundary done", 32'(done_a), 1);
    dn_a = 0; os_a = 0;
    for (int k = 0; k < 5; k++) tick("halted");
    chk("halted count", 32'(count_a), 0);
    chk("halted done", 32'(done_a), 1);
    ld_a = 1; lv_a = 8'd5;
    tick("reload");
    chk("reload count", 32'(count_a), 5);
    chk("reload done", 32'(done_a), 0);
    ld_a = 0;
    tick("resume");
    chk("resume count", 32'(count_a), 6);

    // Load clamp and priority over enable on LIMIT=9.
    ld_b = 1; en_b = 1; lv_b = 4'd15;
    tick("clamp");
    chk("clamp count", 32'(count_b), 9);
    chk("clamp wrap", 32'(wrap_b), 0);
    ld_b = 0;

    // Reset in the middle of a cycle at count=100.
    en_a = 0; en_b = 0; dn_a = 0;
    @(negedge clock);
    do_reset();
    en_a = 1;
    for (int k = 0; k < 100; k++) tick("run100");
    chk("run100 count", 32'(count_a), 100);
    #3;
    reset_n = 1'b0;
    #1;
    ma = model_reset(cmp_a);
    mb = model_reset(cmp_b);
    chk("async count", 32'(count_a), 0);
    chk("async wrap", 32'(wrap_a), 0);
    chk("async done", 32'(done_a), 0);
    check_models("async");
    @(negedge clock);
    reset_n = 1'b1;
    tick("after reset");
    chk("after reset count", 32'(count_a), 1);

    // Randomized run against the reference model.
    for (int k = 0; k < 3000; k++) begin
      ld_a = ($urandom_range(0, 19) == 0);
      lv_a = 8'($urandom_range(0, 255));
      en_a = ($urandom_range(0, 3) != 0);
      dn_a = 1'($urandom_range(0, 1));
      os_a = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) cmp_a = 8'($urandom_range(0, 255));
      ld_b = ($urandom_range(0, 19) == 0);
      lv_b = 4'($urandom_range(0, 15));
      en_b = ($urandom_range(0, 3) != 0);
      dn_b = 1'($urandom_range(0, 1));
      os_b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) cmp_b = 4'($urandom_range(0, 15));
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
